model_matrix_scalar_product_function: RTL and testbench

Streaming fixed-point stage that multiplies every element of an I×J matrix by one scalar, typically the key-strength β produced by the matrix oneplus stage, and emits the scaled matrix in row-major order. It sits directly downstream of the oneplus stage in the content-based addressing path and uses the same I/J enable streaming handshake on both sides. Multiplication is sequential (shift-add), one element at a time.

---
 rtl/model_matrix_scalar_product_function_pkg.sv | 46 ++++
 rtl/model_matrix_scalar_product_function_if.sv | 56 +++++
 rtl/model_scalar_fixed_multiplier.sv | 114 +++++++++++
 rtl/model_matrix_scalar_product_function.sv | 198 +++++++++++++++++++
 tb/tb_model_matrix_scalar_product_function.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/model_matrix_scalar_product_function_pkg.sv
// ---------------------------------------------------------------------------
// model_matrix_scalar_product_function_pkg
// Shared definitions for the matrix scalar product stage and its
// fixed-point multiplier:
//   - state_t               : FSM state encoding (3 bits)
//   - ZERO/ONE constants    : control (1-bit) and data (integer) forms
//   - saturation_positive() : largest positive value for a given DATA_SIZE
//   - saturation_negative() : most negative value that is still
//                             symmetric with the positive bound
// ---------------------------------------------------------------------------
package model_matrix_scalar_product_function_pkg;

  typedef enum logic [2:0] {
    STARTER_STATE  = 3'd0,
    INPUT_I_STATE  = 3'd1,
    INPUT_J_STATE  = 3'd2,
    MULTIPLY_STATE = 3'd3,
    ENDER_STATE    = 3'd4
  } state_t;

  localparam logic ZERO_CONTROL = 1'b0;
  localparam logic ONE_CONTROL  = 1'b1;

  localparam int ZERO_DATA = 0;
  localparam int ONE_DATA  = 1;

  // Wide enough for any DATA_SIZE this stage is built with; callers
  // truncate to their own width.
  localparam int MAX_DATA_SIZE = 128;

  // 2^(data_size-1) - 1
  function automatic logic [MAX_DATA_SIZE-1:0] saturation_positive(input int data_size);
    logic [MAX_DATA_SIZE-1:0] one_value;
    one_value = MAX_DATA_SIZE'(ONE_DATA);
    return (one_value << (data_size - 1)) - one_value;
  endfunction

  // -(2^(data_size-1) - 1) in data_size-bit two's complement,
  // i.e. 2^(data_size-1) + 1 once truncated.
  function automatic logic [MAX_DATA_SIZE-1:0] saturation_negative(input int data_size);
    logic [MAX_DATA_SIZE-1:0] one_value;
    one_value = MAX_DATA_SIZE'(ONE_DATA);
    return (one_value << (data_size - 1)) + one_value;
  endfunction

endpackage

// File: rtl/model_matrix_scalar_product_function_if.sv
// ---------------------------------------------------------------------------
// model_matrix_scalar_product_function_if
// Streaming I/J enable bus of the matrix scalar product stage.
//   master : upstream side (drives START, sizes, scalar, DATA_IN and the
//            input enables; receives READY, DATA_OUT, output enables and
//            OVERFLOW)
//   slave  : the scalar product stage itself
// ---------------------------------------------------------------------------
interface model_matrix_scalar_product_function_if #(
  parameter int DATA_SIZE = 64
);

  logic                 START;
  logic                 READY;
  logic                 DATA_IN_I_ENABLE;
  logic                 DATA_IN_J_ENABLE;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 OVERFLOW;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] SCALAR_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START,
    output DATA_IN_I_ENABLE,
    output DATA_IN_J_ENABLE,
    output SIZE_I_IN,
    output SIZE_J_IN,
    output SCALAR_IN,
    output DATA_IN,
    input  READY,
    input  DATA_OUT_I_ENABLE,
    input  DATA_OUT_J_ENABLE,
    input  OVERFLOW,
    input  DATA_OUT
  );

  modport slave (
    input  START,
    input  DATA_IN_I_ENABLE,
    input  DATA_IN_J_ENABLE,
    input  SIZE_I_IN,
    input  SIZE_J_IN,
    input  SCALAR_IN,
    input  DATA_IN,
    output READY,
    output DATA_OUT_I_ENABLE,
    output DATA_OUT_J_ENABLE,
    output OVERFLOW,
    output DATA_OUT
  );

endinterface

// File: rtl/model_scalar_fixed_multiplier.sv
// ---------------------------------------------------------------------------
// model_scalar_fixed_multiplier
// Sequential shift-add signed fixed-point multiplier, one multiplier bit
// per cycle over DATA_SIZE cycles.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   START      in   begin a product (ignored while busy)
//   DATA_A_IN  in   operand A, two's complement fixed point
//   DATA_B_IN  in   operand B, two's complement fixed point
//   READY      out  one-cycle pulse when DATA_OUT/OVERFLOW are final
//   DATA_OUT   out  product >> FRACTIONAL_SIZE, truncated toward zero,
//                   saturated to +/-(2^(DATA_SIZE-1)-1); held until next START
//   OVERFLOW   out  high while the held product is saturated
// START at edge n gives READY high during the cycle after edge n+DATA_SIZE-1,
// so the owner samples it at edge n+DATA_SIZE.
// ---------------------------------------------------------------------------
module model_scalar_fixed_multiplier
  import model_matrix_scalar_product_function_pkg::*;
#(
  parameter int DATA_SIZE       = 64,
  parameter int FRACTIONAL_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 OVERFLOW
);

  localparam int PRODUCT_SIZE = 2 * DATA_SIZE;
  localparam int COUNT_SIZE   = $clog2(DATA_SIZE + 1);
  localparam logic [COUNT_SIZE-1:0] LAST_STEP = COUNT_SIZE'(DATA_SIZE - 1);
  localparam logic [DATA_SIZE-1:0]  SAT_POS   = DATA_SIZE'(saturation_positive(DATA_SIZE));
  localparam logic [DATA_SIZE-1:0]  SAT_NEG   = DATA_SIZE'(saturation_negative(DATA_SIZE));

  logic [DATA_SIZE-1:0]    magnitude_a;
  logic [DATA_SIZE-1:0]    magnitude_b;
  logic [PRODUCT_SIZE-1:0] multiplicand_reg;
  logic [DATA_SIZE-1:0]    multiplier_reg;
  logic [PRODUCT_SIZE-1:0] product_reg;
  logic [COUNT_SIZE-1:0]   count_reg;
  logic                    busy_reg;
  logic                    ready_reg;
  logic                    negative_reg;

  logic [PRODUCT_SIZE-1:0] product_shifted;
  logic [DATA_SIZE-1:0]    magnitude_result;
  logic                    saturated;

  // Unsigned magnitudes. The most negative value maps onto itself, which
  // read as unsigned is exactly 2^(DATA_SIZE-1).
  assign magnitude_a = DATA_A_IN[DATA_SIZE-1] ? (~DATA_A_IN + DATA_SIZE'(ONE_DATA)) : DATA_A_IN;
  assign magnitude_b = DATA_B_IN[DATA_SIZE-1] ? (~DATA_B_IN + DATA_SIZE'(ONE_DATA)) : DATA_B_IN;

  // The START edge already performs the first shift-add step straight from
  // the operand inputs; the remaining DATA_SIZE-1 steps follow one per edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      multiplicand_reg <= '0;
      multiplier_reg   <= '0;
      product_reg      <= '0;
      count_reg        <= '0;
      busy_reg         <= ZERO_CONTROL;
      ready_reg        <= ZERO_CONTROL;
      negative_reg     <= ZERO_CONTROL;
    end else begin
      ready_reg <= ZERO_CONTROL;
      if (START && !busy_reg) begin
        multiplicand_reg <= PRODUCT_SIZE'(magnitude_a) << 1;
        multiplier_reg   <= magnitude_b >> 1;
        product_reg      <= magnitude_b[0] ? PRODUCT_SIZE'(magnitude_a) : '0;
        negative_reg     <= DATA_A_IN[DATA_SIZE-1] ^ DATA_B_IN[DATA_SIZE-1];
        count_reg        <= COUNT_SIZE'(ONE_DATA);
        busy_reg         <= (DATA_SIZE > 1);
        ready_reg        <= (DATA_SIZE == 1);
      end else if (busy_reg) begin
        if (multiplier_reg[0]) begin
          product_reg <= product_reg + multiplicand_reg;
        end
        multiplicand_reg <= multiplicand_reg << 1;
        multiplier_reg   <= multiplier_reg >> 1;
        count_reg        <= count_reg + COUNT_SIZE'(ONE_DATA);
        if (count_reg == LAST_STEP) begin
          busy_reg  <= ZERO_CONTROL;
          ready_reg <= ONE_CONTROL;
        end
      end
    end
  end

  // Drop the fractional bits of the magnitude (truncation toward zero),
  // then saturate symmetrically and re-apply the sign. A zero magnitude
  // negates to zero, so there is no negative zero.
  assign product_shifted  = product_reg >> FRACTIONAL_SIZE;
  assign saturated        = (product_shifted > PRODUCT_SIZE'(SAT_POS));
  assign magnitude_result = product_shifted[DATA_SIZE-1:0];

  always_comb begin
    DATA_OUT = magnitude_result;
    if (saturated) begin
      DATA_OUT = negative_reg ? SAT_NEG : SAT_POS;
    end else if (negative_reg) begin
      DATA_OUT = ~magnitude_result + DATA_SIZE'(ONE_DATA);
    end
  end

  assign OVERFLOW = saturated;
  assign READY    = ready_reg;

endmodule

// File: rtl/model_matrix_scalar_product_function.sv
// ---------------------------------------------------------------------------
// model_matrix_scalar_product_function
// Streams an I x J fixed-point matrix in row-major order and emits every
// element multiplied by one scalar (typically the key strength beta).
// Ports:
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-low reset
//   bus  slave side of model_matrix_scalar_product_function_if:
//        START/READY, sizes, scalar, DATA_IN with I/J input enables,
//        DATA_OUT with I/J output enables, sticky OVERFLOW
// Element timing (edge t accepts an input enable):
//   multiplier START high in the cycle after edge t, its READY sampled at
//   edge t+1+DATA_SIZE, where DATA_OUT and the output pulses are registered;
//   the following cycle (ENDER_STATE) advances the indices, so the next
//   input enable can be accepted at edge t+3+DATA_SIZE.
// ---------------------------------------------------------------------------
module model_matrix_scalar_product_function
  import model_matrix_scalar_product_function_pkg::*;
#(
  parameter int DATA_SIZE       = 64,
  parameter int CONTROL_SIZE    = 4,
  parameter int FRACTIONAL_SIZE = 32
) (
  input logic CLK,
  input logic RST,
  model_matrix_scalar_product_function_if.slave bus
);

  state_t                  state_reg,        state_next;
  logic [DATA_SIZE-1:0]    size_i_reg,       size_i_next;
  logic [DATA_SIZE-1:0]    size_j_reg,       size_j_next;
  logic [DATA_SIZE-1:0]    scalar_reg,       scalar_next;
  logic [DATA_SIZE-1:0]    data_in_reg,      data_in_next;
  logic [DATA_SIZE-1:0]    data_out_reg,     data_out_next;
  logic [CONTROL_SIZE-1:0] index_i_reg,      index_i_next;
  logic [CONTROL_SIZE-1:0] index_j_reg,      index_j_next;
  logic                    ready_reg,        ready_next;
  logic                    out_i_en_reg,     out_i_en_next;
  logic                    out_j_en_reg,     out_j_en_next;
  logic                    overflow_reg,     overflow_next;
  logic                    mult_started_reg, mult_started_next;

  logic                    mult_start;
  logic                    mult_ready;
  logic                    mult_overflow;
  logic [DATA_SIZE-1:0]    mult_product;

  logic                    last_column;
  logic                    last_row;
  logic                    zero_size;

  model_scalar_fixed_multiplier #(
    .DATA_SIZE       (DATA_SIZE),
    .FRACTIONAL_SIZE (FRACTIONAL_SIZE)
  ) u_multiplier (
    .CLK       (CLK),
    .RST       (RST),
    .START     (mult_start),
    .DATA_A_IN (data_in_reg),
    .DATA_B_IN (scalar_reg),
    .READY     (mult_ready),
    .DATA_OUT  (mult_product),
    .OVERFLOW  (mult_overflow)
  );

  assign last_column = (DATA_SIZE'(index_j_reg) == size_j_reg - DATA_SIZE'(ONE_DATA));
  assign last_row    = (DATA_SIZE'(index_i_reg) == size_i_reg - DATA_SIZE'(ONE_DATA));
  assign zero_size   = (bus.SIZE_I_IN == DATA_SIZE'(ZERO_DATA)) ||
                       (bus.SIZE_J_IN == DATA_SIZE'(ZERO_DATA));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg        <= STARTER_STATE;
      size_i_reg       <= '0;
      size_j_reg       <= '0;
      scalar_reg       <= '0;
      data_in_reg      <= '0;
      data_out_reg     <= '0;
      index_i_reg      <= '0;
      index_j_reg      <= '0;
      ready_reg        <= ZERO_CONTROL;
      out_i_en_reg     <= ZERO_CONTROL;
      out_j_en_reg     <= ZERO_CONTROL;
      overflow_reg     <= ZERO_CONTROL;
      mult_started_reg <= ZERO_CONTROL;
    end else begin
      state_reg        <= state_next;
      size_i_reg       <= size_i_next;
      size_j_reg       <= size_j_next;
      scalar_reg       <= scalar_next;
      data_in_reg      <= data_in_next;
      data_out_reg     <= data_out_next;
      index_i_reg      <= index_i_next;
      index_j_reg      <= index_j_next;
      ready_reg        <= ready_next;
      out_i_en_reg     <= out_i_en_next;
      out_j_en_reg     <= out_j_en_next;
      overflow_reg     <= overflow_next;
      mult_started_reg <= mult_started_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    size_i_next       = size_i_reg;
    size_j_next       = size_j_reg;
    scalar_next       = scalar_reg;
    data_in_next      = data_in_reg;
    data_out_next     = data_out_reg;
    index_i_next      = index_i_reg;
    index_j_next      = index_j_reg;
    overflow_next     = overflow_reg;
    mult_started_next = mult_started_reg;
    // Output strobes are single-cycle pulses unless set below.
    ready_next        = ZERO_CONTROL;
    out_i_en_next     = ZERO_CONTROL;
    out_j_en_next     = ZERO_CONTROL;
    mult_start        = ZERO_CONTROL;

    case (state_reg)
      STARTER_STATE: begin
        if (bus.START) begin
          size_i_next   = bus.SIZE_I_IN;
          size_j_next   = bus.SIZE_J_IN;
          scalar_next   = bus.SCALAR_IN;
          overflow_next = ZERO_CONTROL;
          index_i_next  = '0;
          index_j_next  = '0;
          if (zero_size) begin
            // Empty matrix: nothing to emit, just report completion.
            ready_next = ONE_CONTROL;
          end else begin
            state_next = INPUT_I_STATE;
          end
        end
      end

      INPUT_I_STATE: begin
        if (bus.DATA_IN_I_ENABLE) begin
          data_in_next = bus.DATA_IN;
          state_next   = MULTIPLY_STATE;
        end
      end

      INPUT_J_STATE: begin
        if (bus.DATA_IN_J_ENABLE) begin
          data_in_next = bus.DATA_IN;
          state_next   = MULTIPLY_STATE;
        end
      end

      MULTIPLY_STATE: begin
        // Kick the multiplier exactly once per element.
        mult_start        = !mult_started_reg;
        mult_started_next = ONE_CONTROL;
        if (mult_started_reg && mult_ready) begin
          // Register the result on entry to ENDER so it is visible during
          // ENDER while the indices advance.
          mult_started_next = ZERO_CONTROL;
          data_out_next     = mult_product;
          out_j_en_next     = ONE_CONTROL;
          overflow_next     = overflow_reg | mult_overflow;
          if (last_column) begin
            out_i_en_next = ONE_CONTROL;
            ready_next    = last_row;
          end
          state_next = ENDER_STATE;
        end
      end

      ENDER_STATE: begin
        if (last_column && last_row) begin
          index_i_next = '0;
          index_j_next = '0;
          state_next   = STARTER_STATE;
        end else if (last_column) begin
          index_i_next = index_i_reg + CONTROL_SIZE'(ONE_DATA);
          index_j_next = '0;
          state_next   = INPUT_I_STATE;
        end else begin
          index_j_next = index_j_reg + CONTROL_SIZE'(ONE_DATA);
          state_next   = INPUT_J_STATE;
        end
      end

      default: begin
        state_next = STARTER_STATE;
      end
    endcase
  end

  assign bus.READY             = ready_reg;
  assign bus.DATA_OUT_I_ENABLE = out_i_en_reg;
  assign bus.DATA_OUT_J_ENABLE = out_j_en_reg;
  assign bus.OVERFLOW          = overflow_reg;
  assign bus.DATA_OUT          = data_out_reg;

endmodule

// File: tb/tb_model_matrix_scalar_product_function.sv
// ---------------------------------------------------------------------------
// tb_model_matrix_scalar_product_function
// Directed bench for the matrix scalar product stage with DATA_SIZE=16,
// FRACTIONAL_SIZE=8: a table of 1x1 products plus hand-written sequences
// for row/column ordering, ignored stray inputs, zero sizes and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_model_matrix_scalar_product_function;

  localparam int DS      = 16;
  localparam int CS      = 4;
  localparam int FS      = 8;
  localparam int LATENCY = DS + 1;   // rising edges after the accepting edge

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  model_matrix_scalar_product_function_if #(.DATA_SIZE(DS)) bus ();

  model_matrix_scalar_product_function #(
    .DATA_SIZE       (DS),
    .CONTROL_SIZE    (CS),
    .FRACTIONAL_SIZE (FS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [DS-1:0] scalar;
    logic [DS-1:0] element;
    logic [DS-1:0] exp_out;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs [11];

  int n_applied    = 0;
  int n_miscompare = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic start_matrix(input logic [DS-1:0] si, input logic [DS-1:0] sj,
                              input logic [DS-1:0] sc);
    bus.SIZE_I_IN = si;
    bus.SIZE_J_IN = sj;
    bus.SCALAR_IN = sc;
    bus.START     = 1'b1;
    tick();
    bus.START     = 1'b0;
  endtask

  task automatic feed(input bit row_first, input logic [DS-1:0] d);
    bus.DATA_IN = d;
    if (row_first) bus.DATA_IN_I_ENABLE = 1'b1;
    else           bus.DATA_IN_J_ENABLE = 1'b1;
    tick();
    bus.DATA_IN_I_ENABLE = 1'b0;
    bus.DATA_IN_J_ENABLE = 1'b0;
  endtask

  // One-cycle pulse of an enable that the current state must ignore.
  task automatic stray(input bit use_i, input logic [DS-1:0] d);
    bus.DATA_IN = d;
    if (use_i) bus.DATA_IN_I_ENABLE = 1'b1;
    else       bus.DATA_IN_J_ENABLE = 1'b1;
    tick();
    bus.DATA_IN_I_ENABLE = 1'b0;
    bus.DATA_IN_J_ENABLE = 1'b0;
  endtask

  // Counts rising edges until DATA_OUT_J_ENABLE shows up (bounded). With
  // mid_noise set, a J enable and a zero-size START are pulsed mid-multiply.
  task automatic wait_out(input bit mid_noise, output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (mid_noise && lat == 4) begin
        bus.DATA_IN_J_ENABLE = 1'b1;
        bus.DATA_IN          = 16'h7777;
        bus.START            = 1'b1;
        bus.SIZE_I_IN        = 16'h0000;
      end else if (mid_noise && lat == 5) begin
        bus.DATA_IN_J_ENABLE = 1'b0;
        bus.START            = 1'b0;
      end
      if (bus.DATA_OUT_J_ENABLE) break;
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int lat;
    start_matrix(16'd1, 16'd1, v.scalar);
    check("ovf_cleared_by_start", 32'(bus.OVERFLOW), 32'd0);
    feed(1'b1, v.element);
    wait_out(1'b0, lat);
    check("latency", 32'(lat), 32'(LATENCY));
    check("data_out", 32'(bus.DATA_OUT), 32'(v.exp_out));
    check("i_enable_last", 32'(bus.DATA_OUT_I_ENABLE), 32'd1);
    check("ready_last", 32'(bus.READY), 32'd1);
    check("overflow", 32'(bus.OVERFLOW), 32'(v.exp_ovf));
    $display("vec %0d: scalar=%h elem=%h -> out=%h ovf=%b lat=%0d",
             idx, v.scalar, v.element, bus.DATA_OUT, bus.OVERFLOW, lat);
    tick();
    check("j_enable_one_cycle", 32'(bus.DATA_OUT_J_ENABLE), 32'd0);
    check("ready_one_cycle", 32'(bus.READY), 32'd0);
    check("data_out_held", 32'(bus.DATA_OUT), 32'(v.exp_out));
  endtask

  initial begin
    int lat;
    int seen;
    logic [DS-1:0] elem;

    vecs[0]  = '{16'h0180, 16'h0200, 16'h0300, 1'b0};  //  1.5 *  2.0
    vecs[1]  = '{16'h0180, 16'hFF00, 16'hFE80, 1'b0};  //  1.5 * -1.0
    vecs[2]  = '{16'hFF00, 16'hFF00, 16'h0100, 1'b0};  // -1.0 * -1.0
    vecs[3]  = '{16'h7F00, 16'h0200, 16'h7FFF, 1'b1};  // 127 * 2 saturates
    vecs[4]  = '{16'h7F00, 16'hFE00, 16'h8001, 1'b1};  // 127 * -2 saturates
    vecs[5]  = '{16'h8000, 16'h0100, 16'h8001, 1'b1};  // -128 * 1 saturates
    vecs[6]  = '{16'h0001, 16'h0001, 16'h0000, 1'b0};  // underflows to 0
    vecs[7]  = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0};  // no negative zero
    vecs[8]  = '{16'h0080, 16'hFFFD, 16'hFFFF, 1'b0};  // truncate toward 0
    vecs[9]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};  // exactly max, no sat
    vecs[10] = '{16'h0080, 16'h8000, 16'hC000, 1'b0};  // 0.5 * -128

    bus.START            = 1'b0;
    bus.DATA_IN_I_ENABLE = 1'b0;
    bus.DATA_IN_J_ENABLE = 1'b0;
    bus.SIZE_I_IN        = '0;
    bus.SIZE_J_IN        = '0;
    bus.SCALAR_IN        = '0;
    bus.DATA_IN          = '0;

    // Reset state
    #1;
    check("rst_data_out", 32'(bus.DATA_OUT), 32'd0);
    check("rst_ready", 32'(bus.READY), 32'd0);
    check("rst_j_enable", 32'(bus.DATA_OUT_J_ENABLE), 32'd0);
    check("rst_i_enable", 32'(bus.DATA_OUT_I_ENABLE), 32'd0);
    check("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Table of 1x1 products
    for (int v = 0; v < 11; v++) begin
      run_vector(vecs[v], v);
    end

    // 2x3 matrix, row-major order with ignored stray inputs
    start_matrix(16'd2, 16'd3, 16'h0200);
    stray(1'b0, 16'h5555);                 // J enable while waiting for I
    for (int k = 1; k <= 6; k++) begin
      elem = DS'(k) << 8;
      feed(k == 1 || k == 4, elem);
      wait_out(k == 2, lat);
      check("m23_latency", 32'(lat), 32'(LATENCY));
      check("m23_data_out", 32'(bus.DATA_OUT), 32'(DS'(k) << 9));
      check("m23_i_enable", 32'(bus.DATA_OUT_I_ENABLE), 32'(k == 3 || k == 6));
      check("m23_ready", 32'(bus.READY), 32'(k == 6));
      $display("m23 elem %0d: in=%h out=%h i_en=%b ready=%b",
               k, elem, bus.DATA_OUT, bus.DATA_OUT_I_ENABLE, bus.READY);
      tick();                              // ENDER cycle
      if (k == 1) stray(1'b1, 16'h3333);   // I enable while waiting for J
      if (k == 3) stray(1'b0, 16'h4444);   // J enable while waiting for I
    end
    check("m23_overflow", 32'(bus.OVERFLOW), 32'd0);

    // Zero sizes: READY right after START, nothing emitted
    start_matrix(16'd0, 16'd3, 16'h0100);
    check("zero_i_ready", 32'(bus.READY), 32'd1);
    check("zero_i_j_enable", 32'(bus.DATA_OUT_J_ENABLE), 32'd0);
    $display("zero size I: ready=%b j_en=%b", bus.READY, bus.DATA_OUT_J_ENABLE);
    tick();
    check("zero_i_ready_pulse", 32'(bus.READY), 32'd0);
    start_matrix(16'd2, 16'd0, 16'h0100);
    check("zero_j_ready", 32'(bus.READY), 32'd1);
    check("zero_j_j_enable", 32'(bus.DATA_OUT_J_ENABLE), 32'd0);
    $display("zero size J: ready=%b j_en=%b", bus.READY, bus.DATA_OUT_J_ENABLE);
    tick();
    check("zero_j_ready_pulse", 32'(bus.READY), 32'd0);

    // Reset during the second element's multiply
    start_matrix(16'd1, 16'd2, 16'h7F00);
    feed(1'b1, 16'h0200);
    wait_out(1'b0, lat);
    check("rmid_first_out", 32'(bus.DATA_OUT), 32'h7FFF);
    check("rmid_first_ovf", 32'(bus.OVERFLOW), 32'd1);
    tick();
    feed(1'b0, 16'h0100);
    repeat (5) tick();
    RST = 1'b0;
    #1;
    check("rmid_data_out", 32'(bus.DATA_OUT), 32'd0);
    check("rmid_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("rmid_j_enable", 32'(bus.DATA_OUT_J_ENABLE), 32'd0);
    check("rmid_ready", 32'(bus.READY), 32'd0);
    $display("reset mid-multiply: out=%h ovf=%b", bus.DATA_OUT, bus.OVERFLOW);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.DATA_OUT_J_ENABLE || bus.READY) seen++;
    end
    check("rmid_discarded", 32'(seen), 32'd0);
    run_vector(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule
